data_mem_ctrl: RTL and testbench

Parametrised word-organised data memory for the MIPS_Lite datapath, successor to the 8-bit single-port data memory. It supports byte, halfword and word load/store with per-lane write enables, sign or zero extension on loads, a registered one-cycle read, and a valid/ready request handshake. Alignment and range errors are reported to the pipeline. A sequential clear engine zeroes the array after reset or on command, one word per cycle, instead of a single-cycle array reset.

---
 rtl/data_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access and a one-cycle registered response.
// A sequential clear engine zeroes one word per cycle after reset or on a clear command.
module data_mem_ctrl #(
  parameter int BYTE_LANES = 4,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 8,
  localparam int DATA_W    = 8 * BYTE_LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e              state_q;
  logic [MEM_AW-1:0]   clr_idx_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]    widx;
  logic [MEM_AW-1:0]   ridx;
  logic [1:0]          lane;
  logic                accept;
  logic                err;
  logic                sz_b;
  logic                sz_h;
  logic                sz_w;
  logic [BYTE_LANES-1:0] be;
  logic [DATA_W-1:0]   wdata_al;
  logic [DATA_W-1:0]   rword;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   rdata_d;

  logic [BYTE_LANES-1:0] mem_we;
  logic [MEM_AW-1:0]   mem_widx;
  logic [DATA_W-1:0]   mem_wdata;

  assign widx      = req_addr[ADDR_W-1:2];
  assign ridx      = widx[MEM_AW-1:0];
  assign lane      = req_addr[1:0];
  assign busy      = (state_q == S_CLEAR);
  assign req_ready = (state_q == S_IDLE) && !clr;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign sz_b = (req_size == 2'b00);
  assign sz_h = (req_size == 2'b01);
  assign sz_w = (req_size == 2'b10);

  assign err = (req_size == 2'b11)
             || (sz_h && req_addr[0])
             || (sz_w && (lane != 2'b00))
             || (32'(widx) >= DEPTH);

  assign rword    = mem_q[ridx];
  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    be       = '0;
    wdata_al = req_wdata;
    load_val = rword;
    unique case (1'b1)
      sz_b: begin
        be       = BYTE_LANES'(1) << lane;
        wdata_al = {BYTE_LANES{req_wdata[7:0]}};
        load_val = {{(DATA_W-8){req_signed & byte_sel[7]}},
                    byte_sel};
      end
      sz_h: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_al = {(BYTE_LANES/2){req_wdata[15:0]}};
        load_val = {{(DATA_W-16){req_signed & half_sel[15]}},
                    half_sel};
      end
      sz_w: begin
        be       = '1;
        wdata_al = req_wdata;
        load_val = rword;
      end
      default: begin
        be       = '0;
        wdata_al = req_wdata;
        load_val = '0;
      end
    endcase
  end

  assign rdata_d = (err || req_we) ? '0 : load_val;

  always_comb begin
    mem_we    = '0;
    mem_widx  = ridx;
    mem_wdata = wdata_al;
    if (state_q == S_CLEAR) begin
      mem_we    = '1;
      mem_widx  = clr_idx_q;
      mem_wdata = '0;
    end else if (accept && req_we && !err) begin
      mem_we    = be;
      mem_widx  = ridx;
      mem_wdata = wdata_al;
    end
  end

  // Array itself carries no reset; the clear engine zeroes it instead.
  always_ff @(posedge clk) begin
    for (int l = 0; l < BYTE_LANES; l++) begin
      if (mem_we[l]) begin
        mem_q[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rdata_q <= rdata_d;
        rsp_err_q   <= err;
      end
      unique case (state_q)
        S_CLEAR: begin
          if (clr_idx_q == MEM_AW'(DEPTH - 1)) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table plus clear/reset/back-to-back sequences.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        clr;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests;
  int n_fail;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .clr        (clr),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic we,
                     input logic [1:0] size, input logic sgn,
                     input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input logic e);
    vec_t v;
    v.name = n; v.we = we; v.size = size; v.sgn = sgn;
    v.addr = addr; v.wdata = wd; v.rdata = rd; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // Issue one request at a falling edge and check its response one cycle later.
  task automatic do_req(input vec_t v);
    @(negedge clk);
    chk({v.name, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    chk({v.name, " ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({v.name, " rdata"}, rsp_rdata, v.rdata);
    chk({v.name, " err"}, 32'(rsp_err), 32'(v.err));
  endtask

  task automatic wait_clear(input string n);
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({n, " busy cycles"}, 32'(cnt), 32'd64);
    chk({n, " ready after clear"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load_w(input string n, input logic [7:0] a,
                        input logic [31:0] exp);
    vec_t v;
    v.name = n; v.we = 1'b0; v.size = 2'b10; v.sgn = 1'b0;
    v.addr = a; v.wdata = '0; v.rdata = exp; v.err = 1'b0;
    do_req(v);
  endtask

  task automatic store_w(input string n, input logic [7:0] a,
                         input logic [31:0] d);
    vec_t v;
    v.name = n; v.we = 1'b1; v.size = 2'b10; v.sgn = 1'b0;
    v.addr = a; v.wdata = d; v.rdata = '0; v.err = 1'b0;
    do_req(v);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    clr        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    add("ld w 00",    0, 2'b10, 0, 8'h00, 0, 32'h0, 0);
    add("ld w 7C",    0, 2'b10, 0, 8'h7C, 0, 32'h0, 0);
    add("ld w FC",    0, 2'b10, 0, 8'hFC, 0, 32'h0, 0);
    add("st w 04",    1, 2'b10, 0, 8'h04, 32'h12345678, 32'h0, 0);
    add("ld bu 07",   0, 2'b00, 0, 8'h07, 0, 32'h00000012, 0);
    add("ld hs 04",   0, 2'b01, 1, 8'h04, 0, 32'h00005678, 0);
    add("ld hs 06",   0, 2'b01, 1, 8'h06, 0, 32'h00001234, 0);
    add("ld w 04",    0, 2'b10, 1, 8'h04, 0, 32'h12345678, 0);
    add("st b 09",    1, 2'b00, 0, 8'h09, 32'hFFFFFFF0, 32'h0, 0);
    add("ld bs 09",   0, 2'b00, 1, 8'h09, 0, 32'hFFFFFFF0, 0);
    add("ld bu 09",   0, 2'b00, 0, 8'h09, 0, 32'h000000F0, 0);
    add("ld w 08",    0, 2'b10, 0, 8'h08, 0, 32'h0000F000, 0);
    add("ld hs 08",   0, 2'b01, 1, 8'h08, 0, 32'hFFFFF000, 0);
    add("ld hu 08",   0, 2'b01, 0, 8'h08, 0, 32'h0000F000, 0);
    add("st w 02",    1, 2'b10, 0, 8'h02, 32'hDEADBEEF, 32'h0, 1);
    add("st h 05",    1, 2'b01, 0, 8'h05, 32'hDEADBEEF, 32'h0, 1);
    add("st sz3 00",  1, 2'b11, 0, 8'h00, 32'hDEADBEEF, 32'h0, 1);
    add("ld w 04 b",  0, 2'b10, 0, 8'h04, 0, 32'h12345678, 0);
    add("ld h 03",    0, 2'b01, 0, 8'h03, 0, 32'h0, 1);
    add("ld w 00 b",  0, 2'b10, 0, 8'h00, 0, 32'h0, 0);
    add("st h 0E",    1, 2'b01, 0, 8'h0E, 32'h0000BEEF, 32'h0, 0);
    add("ld w 0C",    0, 2'b10, 0, 8'h0C, 0, 32'hBEEF0000, 0);

    // Reset state
    #12;
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    wait_clear("post-reset");

    foreach (vecs[i]) do_req(vecs[i]);

    // Store then load of the same word on consecutive edges
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 8'h10; req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("b2b st rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b st rdata", rsp_rdata, 32'd0);
    req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b ld rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b ld rdata", rsp_rdata, 32'hAABBCCDD);
    @(negedge clk);
    chk("b2b tail rsp_valid", 32'(rsp_valid), 32'd0);
    chk("b2b hold rdata", rsp_rdata, 32'hAABBCCDD);

    // clr together with a request: request dropped, array cleared
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_size = 2'b10; req_addr = 8'h20; req_wdata = 32'h11111111;
    #1;
    chk("clr ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    chk("clr no rsp", 32'(rsp_valid), 32'd0);
    chk("clr busy", 32'(busy), 32'd1);
    wait_clear("clr");
    load_w("clr ld 04", 8'h04, 32'h0);
    load_w("clr ld 08", 8'h08, 32'h0);
    load_w("clr ld 0C", 8'h0C, 32'h0);
    load_w("clr ld 10", 8'h10, 32'h0);
    load_w("clr ld 20", 8'h20, 32'h0);

    // Reset while a response is pending drops it
    store_w("pre st 30", 8'h30, 32'h55555555);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 8'h34; req_wdata = 32'h77777777;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pend rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("pend dropped", 32'(rsp_valid), 32'd0);
    chk("pend busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    wait_clear("pend reset");
    load_w("pend ld 30", 8'h30, 32'h0);
    load_w("pend ld 34", 8'h34, 32'h0);

    // Reset in the middle of a clear restarts the full sweep
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid rst ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    wait_clear("mid reset");
    store_w("final st 00", 8'h00, 32'hCAFEF00D);
    load_w("final ld 00", 8'h00, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
